led_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one registered seven-segment decoder (BCD `Number` in, segment pins out, one-cycle latency) across `DIGITS` common-anode digits. It double-buffers a packed BCD value, steps through the digits with a per-slot guard interval that hides decoder latency and prevents ghosting, and drives active-low digit enables. It also applies leading-zero suppression and blanks non-BCD nibbles. It sits between the lab datapath, which supplies the value, and the decoder plus board digit pins.

---
 rtl/led_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_led_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for a shared registered seven-segment decoder.
// Double-buffers a packed BCD value, scans digits with a dark guard interval per slot.
module led_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DWELL  = 50000,
    parameter int unsigned GUARD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [3:0]            Number,
    output logic [DIGITS-1:0]     DigitSel,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned VAL_W   = 4 * DIGITS;
    localparam int unsigned IDX_W   = $clog2(DIGITS);
    localparam int unsigned CNT_MAX = (GUARD > DWELL) ? GUARD : DWELL;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [VAL_W-1:0]    r_shadow, w_shadow_nxt;
    logic [VAL_W-1:0]    r_active, w_active_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_blank, w_blank_nxt;
    logic [3:0]          r_number, w_number_nxt;
    logic [DIGITS-1:0]   r_sel, w_sel_nxt;
    logic                r_pending, w_pending_nxt;
    logic                r_frame_done, w_frame_done_nxt;

    logic                w_enter_guard;
    logic [DIGITS-1:0]   w_sel_lit;
    logic [3:0]          w_nib;
    logic                w_zero_above;

    // Next-state, commit and output decode
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + CNT_W'(1);
        w_idx_nxt        = r_idx;
        w_shadow_nxt     = load ? value_in : r_shadow;
        w_active_nxt     = r_active;
        w_pending_nxt    = load ? 1'b1 : r_pending;
        w_number_nxt     = r_number;
        w_sel_nxt        = r_sel;
        w_blank_nxt      = r_blank;
        w_frame_done_nxt = 1'b0;
        w_enter_guard    = 1'b0;
        w_nib            = 4'h0;
        w_zero_above     = 1'b1;

        for (int k = 0; k < int'(DIGITS); k++) begin
            w_sel_lit[k] = (IDX_W'(k) != r_idx);
        end

        case (r_state)
            ST_GUARD: begin
                if (r_cnt == GUARD_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = r_blank ? '1 : w_sel_lit;
                end
            end
            ST_SHOW: begin
                if (r_cnt == DWELL_LAST) begin
                    w_state_nxt   = ST_GUARD;
                    w_cnt_nxt     = '0;
                    w_sel_nxt     = '1;
                    w_enter_guard = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt        = '0;
                        w_frame_done_nxt = 1'b1;
                        // A load on the boundary cycle bypasses the shadow
                        if (load) begin
                            w_active_nxt  = value_in;
                            w_pending_nxt = 1'b0;
                        end else if (r_pending) begin
                            w_active_nxt  = r_shadow;
                            w_pending_nxt = 1'b0;
                        end
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_GUARD;
        endcase

        // Digit selection and leading-zero test for the slot about to start
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (IDX_W'(k) == w_idx_nxt) begin
                w_nib = w_active_nxt[k*4 +: 4];
            end
            if ((IDX_W'(k) >= w_idx_nxt) && (w_active_nxt[k*4 +: 4] != 4'h0)) begin
                w_zero_above = 1'b0;
            end
        end

        if (w_enter_guard) begin
            w_blank_nxt  = (w_nib > 4'd9) ||
                           (lz_en && (w_idx_nxt != '0) && w_zero_above);
            w_number_nxt = w_blank_nxt ? 4'h0 : w_nib;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_GUARD;
            r_shadow     <= '0;
            r_active     <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_blank      <= 1'b0;
            r_number     <= 4'h0;
            r_sel        <= '1;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow     <= w_shadow_nxt;
            r_active     <= w_active_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_blank      <= w_blank_nxt;
            r_number     <= w_number_nxt;
            r_sel        <= w_sel_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign Number     = r_number;
    assign DigitSel   = r_sel;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: expected slot contents are queued at load
// time and compared cycle by cycle as the controller scans each frame.
module tb_led_scan_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned GUARD  = 2;
    localparam int unsigned SLOT   = GUARD + DWELL;
    localparam int unsigned FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  Number;
    logic [3:0]  DigitSel;
    logic        pending;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] num;
        logic [3:0] sel;
    } slot_t;

    slot_t exp_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    led_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .lz_en      (lz_en),
        .Number     (Number),
        .DigitSel   (DigitSel),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Expected per-slot Number and DigitSel for a committed value
    function automatic void push_frame(input logic [15:0] v, input logic lz);
        for (int k = 0; k < 4; k++) begin
            logic [3:0]  nib;
            logic [15:0] upper;
            logic        blank;
            slot_t       s;
            nib   = v[k*4 +: 4];
            upper = v >> (4 * k);
            blank = (nib > 4'd9) || (lz && (k != 0) && (upper == 16'h0));
            s.num = blank ? 4'h0 : nib;
            s.sel = blank ? 4'hF : ~(4'b0001 << k);
            exp_q.push_back(s);
        end
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL frame_wait got=no_pulse exp=pulse_within_%0d", budget);
        else n_pass++;
    endtask

    // Starts on the first cycle of a frame, ends on its last cycle
    task automatic scan_frame(input bit first);
        slot_t s;
        for (int sl = 0; sl < 4; sl++) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard slot=%0d got=empty exp=entry", sl);
                return;
            end
            n_pass++;
            s = exp_q.pop_front();
            for (int c = 0; c < int'(SLOT); c++) begin
                logic [3:0] e_sel;
                logic       e_fd;
                if (sl != 0 || c != 0) begin
                    @(posedge clk);
                    #1;
                end
                e_sel = (c < int'(GUARD)) ? 4'hF : s.sel;
                e_fd  = (sl == 0) && (c == 0) && !first;
                n_total++;
                if (DigitSel !== e_sel)
                    $display("FAIL digitsel slot=%0d cyc=%0d got=%b exp=%b", sl, c, DigitSel, e_sel);
                else n_pass++;
                n_total++;
                if (Number !== s.num)
                    $display("FAIL number slot=%0d cyc=%0d got=%0d exp=%0d", sl, c, Number, s.num);
                else n_pass++;
                n_total++;
                if (frame_done !== e_fd)
                    $display("FAIL frame_done slot=%0d cyc=%0d got=%b exp=%b", sl, c, frame_done, e_fd);
                else n_pass++;
                n_total++;
                if (pending !== 1'b0)
                    $display("FAIL pending_scan slot=%0d cyc=%0d got=%b exp=0", sl, c, pending);
                else n_pass++;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        exp_q.delete();
        push_frame(v, lz_en);
        @(posedge clk);
        #1;
        load = 1'b0;
        n_total++;
        if (pending !== 1'b1) $display("FAIL pending_rise val=%h got=%b exp=1", v, pending);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        lz_en = 1'b1;
        cycles(3);
        n_total++;
        if (DigitSel !== 4'hF) $display("FAIL reset_digitsel got=%b exp=1111", DigitSel); else n_pass++;
        n_total++;
        if (Number !== 4'h0) $display("FAIL reset_number got=%0d exp=0", Number); else n_pass++;
        n_total++;
        if (pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", pending); else n_pass++;
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else n_pass++;
        rst = 1'b1;
        exp_q.delete();
        push_frame(16'h0000, 1'b1);
        scan_frame(1'b1);
    endtask

    task automatic test_idle();
        repeat (2) begin
            push_frame(16'h0000, 1'b1);
            wait_frame(1);
            scan_frame(1'b0);
        end
    endtask

    task automatic test_load_1234();
        lz_en = 1'b1;
        cycles(5);
        do_load(16'h1234);
        cycles(3);
        n_total++;
        if (pending !== 1'b1) $display("FAIL pending_hold got=%b exp=1", pending); else n_pass++;
        wait_frame(FRAME);
        scan_frame(1'b0);
    endtask

    task automatic test_lz_0050();
        lz_en = 1'b1;
        cycles(5);
        do_load(16'h0050);
        wait_frame(FRAME);
        scan_frame(1'b0);
    endtask

    task automatic test_invalid();
        lz_en = 1'b0;
        cycles(4);
        do_load(16'h00A7);
        wait_frame(FRAME);
        scan_frame(1'b0);
    endtask

    task automatic test_back_to_back();
        cycles(3);
        do_load(16'h1111);
        cycles(2);
        do_load(16'h2222);
        wait_frame(FRAME);
        scan_frame(1'b0);
    endtask

    // Called while sitting on the last cycle of a frame
    task automatic test_boundary_load();
        load     = 1'b1;
        value_in = 16'h9999;
        exp_q.delete();
        push_frame(16'h9999, lz_en);
        @(posedge clk);
        #1;
        load = 1'b0;
        n_total++;
        if (pending !== 1'b0) $display("FAIL boundary_pending got=%b exp=0", pending); else n_pass++;
        scan_frame(1'b0);
    endtask

    task automatic test_reset_mid_show();
        wait_frame(1);
        cycles(2 * SLOT + GUARD);
        n_total++;
        if (DigitSel !== 4'b1011) $display("FAIL show_digit2 got=%b exp=1011", DigitSel); else n_pass++;
        #3;
        rst = 1'b0;
        #1;
        n_total++;
        if (DigitSel !== 4'hF) $display("FAIL async_reset_digitsel got=%b exp=1111", DigitSel); else n_pass++;
        n_total++;
        if (Number !== 4'h0) $display("FAIL async_reset_number got=%0d exp=0", Number); else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (DigitSel !== 4'hF) $display("FAIL reset_hold_digitsel got=%b exp=1111", DigitSel); else n_pass++;
        lz_en = 1'b0;
        rst   = 1'b1;
        exp_q.delete();
        push_frame(16'h0000, 1'b0);
        scan_frame(1'b1);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_1234();
        test_lz_0050();
        test_invalid();
        test_back_to_back();
        test_boundary_load();
        test_reset_mid_show();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
